// File: rtl/fp_mul_pkg.sv
// Shared definitions for the FP multiplier scheduler: FSM encodings, flag bit
// positions and the quiet-NaN word returned when the multiplier hangs.
package fp_mul_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_RESP    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    localparam int FLAG_UNF = 0;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_EXC = 2;
    localparam int FLAG_TMO = 3;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the
// pointer, wrapping, returned both one-hot and as an index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/fp_mul_scheduler.sv
// Shares one single-precision multiplier among N_REQ requesters, one operation
// at a time, with round-robin grant and a watchdog that resets a hung multiplier.
module fp_mul_scheduler
    import fp_mul_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [32*N_REQ-1:0] req_a,
    input  logic [32*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [31:0]        rsp_z,
    output logic [3:0]         rsp_flags,
    output logic [31:0]        mul_a,
    output logic [31:0]        mul_b,
    output logic               mul_dv,
    output logic               mul_rst,
    input  logic [31:0]        mul_z,
    input  logic               mul_exc,
    input  logic               mul_ovf,
    input  logic               mul_unf,
    input  logic               mul_done,
    output logic               busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [31:0]      mul_a_q, mul_a_d;
    logic [31:0]      mul_b_q, mul_b_d;
    logic [31:0]      rsp_z_q, rsp_z_d;
    logic [3:0]       flags_q, flags_d;
    logic             mul_rst_q, mul_rst_d;
    logic             done_prev_q, done_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic             done_rise;
    logic [N_REQ-1:0] gidx_onehot;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Grants are held off while the multiplier is still coming out of reset.
    assign req_ready   = (state_q == ST_IDLE && !mul_rst_q) ? arb_grant : '0;
    assign gidx_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << gidx_q;
    assign rsp_valid   = (state_q == ST_RESP) ? gidx_onehot : '0;
    assign mul_dv      = (state_q == ST_ISSUE);
    assign busy        = (state_q != ST_IDLE);
    assign mul_rst     = mul_rst_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign rsp_z       = rsp_z_q;
    assign rsp_flags   = flags_q;
    assign done_rise   = mul_done && !done_prev_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_z_d     = rsp_z_q;
        flags_d     = flags_q;
        mul_rst_d   = 1'b0;
        done_prev_d = mul_done;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any && !mul_rst_q) begin
                    gidx_d  = arb_idx;
                    mul_a_d = req_a[32*arb_idx +: 32];
                    mul_b_d = req_b[32*arb_idx +: 32];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done level left over from an earlier op never counts; only a fresh rise.
                if (done_rise) begin
                    rsp_z_d           = mul_z;
                    flags_d           = '0;
                    flags_d[FLAG_EXC] = mul_exc;
                    flags_d[FLAG_OVF] = mul_ovf;
                    flags_d[FLAG_UNF] = mul_unf;
                    state_d           = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_z_d           = QNAN;
                    flags_d           = '0;
                    flags_d[FLAG_TMO] = 1'b1;
                    mul_rst_d         = 1'b1;
                    state_d           = ST_RECOVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RECOVER: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[gidx_q]) begin
                    ptr_d   = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_z_q     <= '0;
            flags_q     <= '0;
            mul_rst_q   <= 1'b1;
            done_prev_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_z_q     <= rsp_z_d;
            flags_q     <= flags_d;
            mul_rst_q   <= mul_rst_d;
            done_prev_q <= done_prev_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
